plugboard_mapper: RTL and testbench

Programmable, parametrised plugboard stage for the Enigma datapath. It holds a letter-swap table that is loaded at run time through a configuration handshake, then substitutes each incoming letter index through that table behind a registered valid/ready stream. It sits between the keyboard encoder and the rotor stack. The same instance serves the return path when the stream is time-multiplexed.

---
 rtl/plugboard_mapper_if.sv | 30 +++
 rtl/plugboard_mapper.sv | 119 +++++++++++
 tb/tb_plugboard_mapper.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/plugboard_mapper_if.sv
// Configuration and letter-stream bundle for the plugboard stage.
// The master side drives config/input requests; the slave side is the mapper.
interface plugboard_mapper_if #(
   parameter int W  = 5,
   parameter int CW = 4
);
   logic          cfg_clear;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [W-1:0]  cfg_a;
   logic [W-1:0]  cfg_b;
   logic          cfg_err;
   logic [CW-1:0] pair_count;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_letter;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_letter;

   modport master (
      output cfg_clear, cfg_valid, cfg_a, cfg_b, in_valid, in_letter, out_ready,
      input  cfg_ready, cfg_err, pair_count, in_ready, out_valid, out_letter
   );

   modport slave (
      input  cfg_clear, cfg_valid, cfg_a, cfg_b, in_valid, in_letter, out_ready,
      output cfg_ready, cfg_err, pair_count, in_ready, out_valid, out_letter
   );
endinterface

// File: rtl/plugboard_mapper.sv
// Run-time programmable letter-swap stage: a pair table loaded over a config
// handshake, applied to a registered valid/ready letter stream.
module plugboard_mapper #(
   parameter int ALPHA     = 26,
   parameter int W         = 5,
   parameter int MAX_PAIRS = 10,
   parameter int CW        = 4
) (
   input logic               clock,
   input logic               resetn,
   plugboard_mapper_if.slave bus
);

   typedef enum logic {RUN, CLEAR} state_t;

   state_t        r_state, w_state_nxt;
   logic [W-1:0]  r_clr_idx, w_clr_idx_nxt;
   logic [W-1:0]  r_table [ALPHA];
   logic [CW-1:0] r_pair_count;
   logic          r_cfg_err;
   logic          r_out_valid;
   logic [W-1:0]  r_out_letter;

   logic          w_run;
   logic          w_cfg_hs, w_in_hs;
   logic          w_reject, w_accept;
   logic [W-1:0]  w_ta, w_tb, w_tin;

   assign w_run         = (r_state == RUN);
   assign bus.cfg_ready = w_run && !bus.cfg_clear;
   assign bus.in_ready  = w_run && !bus.cfg_clear && (!r_out_valid || bus.out_ready);
   assign w_cfg_hs      = bus.cfg_valid && bus.cfg_ready;
   assign w_in_hs       = bus.in_valid && bus.in_ready;

   // Out-of-range indices fall through the mux unchanged, which is exactly
   // the pass-through behaviour wanted for stray input letters.
   always_comb begin
      w_ta  = bus.cfg_a;
      w_tb  = bus.cfg_b;
      w_tin = bus.in_letter;
      for (int k = 0; k < ALPHA; k++) begin
         if (bus.cfg_a == W'(k))     w_ta  = r_table[k];
         if (bus.cfg_b == W'(k))     w_tb  = r_table[k];
         if (bus.in_letter == W'(k)) w_tin = r_table[k];
      end
   end

   assign w_reject = (bus.cfg_a == bus.cfg_b)
                  || (bus.cfg_a >= W'(ALPHA)) || (bus.cfg_b >= W'(ALPHA))
                  || (w_ta != bus.cfg_a) || (w_tb != bus.cfg_b)
                  || (r_pair_count == CW'(MAX_PAIRS));
   assign w_accept = w_cfg_hs && !w_reject;

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_idx_nxt = r_clr_idx;
      if (bus.cfg_clear) begin
         w_state_nxt   = CLEAR;
         w_clr_idx_nxt = '0;
      end else if (r_state == CLEAR) begin
         w_clr_idx_nxt = r_clr_idx + 1'b1;
         if (r_clr_idx == W'(ALPHA-1)) w_state_nxt = RUN;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state   <= RUN;
         r_clr_idx <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_idx <= w_clr_idx_nxt;
      end
   end

   // Wipe and pair install never coincide: installs need RUN, wipes need CLEAR.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < ALPHA; k++) r_table[k] <= W'(k);
      end else if (r_state == CLEAR) begin
         for (int k = 0; k < ALPHA; k++)
            if (r_clr_idx == W'(k)) r_table[k] <= W'(k);
      end else if (w_accept) begin
         for (int k = 0; k < ALPHA; k++) begin
            if (bus.cfg_a == W'(k)) r_table[k] <= bus.cfg_b;
            if (bus.cfg_b == W'(k)) r_table[k] <= bus.cfg_a;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_pair_count <= '0;
         r_cfg_err    <= 1'b0;
      end else begin
         r_cfg_err <= w_cfg_hs && w_reject;
         if (bus.cfg_clear)  r_pair_count <= '0;
         else if (w_accept)  r_pair_count <= r_pair_count + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_out_valid  <= 1'b0;
         r_out_letter <= '0;
      end else if (w_in_hs) begin
         r_out_valid  <= 1'b1;
         r_out_letter <= w_tin;
      end else if (bus.out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign bus.cfg_err    = r_cfg_err;
   assign bus.pair_count = r_pair_count;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_letter = r_out_letter;

endmodule

// File: tb/tb_plugboard_mapper.sv
// Directed plus randomized bench for plugboard_mapper against a behavioural
// swap-table model (clear modelled as an instant wipe plus a busy countdown).
module tb_plugboard_mapper;
   localparam int ALPHA = 26, W = 5, MAX_PAIRS = 10, CW = 4;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   plugboard_mapper_if #(.W(W), .CW(CW)) bus ();

   plugboard_mapper #(.ALPHA(ALPHA), .W(W), .MAX_PAIRS(MAX_PAIRS), .CW(CW)) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   int n_vec = 0, n_bad = 0;
   int m_tab [ALPHA];
   int m_cnt, m_busy, m_ol;
   bit m_ov, m_err;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int k = 0; k < ALPHA; k++) m_tab[k] = k;
      m_cnt = 0; m_busy = 0; m_ol = 0; m_ov = 0; m_err = 0;
   endtask

   function automatic bit is_reject(input int a, input int b);
      if (a == b || a >= ALPHA || b >= ALPHA) return 1;
      if (m_tab[a] != a || m_tab[b] != b) return 1;
      return (m_cnt == MAX_PAIRS);
   endfunction

   // One clock cycle: drive at negedge, check, then advance the model to the
   // state the DUT will hold after the coming rising edge.
   task automatic step(input bit clr, input bit cv, input int a, input int b,
                       input bit iv, input int il, input bit ordy);
      bit crdy, irdy, chs, ihs, rej;
      @(negedge clock);
      bus.cfg_clear = clr; bus.cfg_valid = cv;
      bus.cfg_a = W'(a);   bus.cfg_b = W'(b);
      bus.in_valid = iv;   bus.in_letter = W'(il);
      bus.out_ready = ordy;
      #1;
      crdy = (m_busy == 0) && !clr;
      irdy = crdy && (!m_ov || ordy);
      chk("cfg_ready",  int'(bus.cfg_ready),  int'(crdy));
      chk("in_ready",   int'(bus.in_ready),   int'(irdy));
      chk("out_valid",  int'(bus.out_valid),  int'(m_ov));
      chk("out_letter", int'(bus.out_letter), m_ol);
      chk("cfg_err",    int'(bus.cfg_err),    int'(m_err));
      chk("pair_count", int'(bus.pair_count), m_cnt);

      chs = cv && crdy;
      ihs = iv && irdy;
      rej = is_reject(a, b);
      if (ihs) begin
         m_ol = (il < ALPHA) ? m_tab[il] : il;
         m_ov = 1;
      end else if (ordy) m_ov = 0;
      m_err = chs && rej;
      if (clr) begin
         for (int k = 0; k < ALPHA; k++) m_tab[k] = k;
         m_busy = ALPHA;
         m_cnt  = 0;
      end else if (m_busy > 0) m_busy--;
      if (chs && !rej) begin
         m_tab[a] = b;
         m_tab[b] = a;
         m_cnt++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic pair(input int a, input int b);
      step(0, 1, a, b, 0, 0, 1);
   endtask

   task automatic send(input int l);
      step(0, 0, 0, 0, 1, l, 1);
   endtask

   task automatic async_reset();
      @(negedge clock);
      bus.cfg_clear = 0; bus.cfg_valid = 0; bus.in_valid = 0; bus.out_ready = 0;
      resetn = 1'b0;
      #1;
      m_reset();
      chk("rst_out_valid",  int'(bus.out_valid),  0);
      chk("rst_out_letter", int'(bus.out_letter), 0);
      chk("rst_cfg_err",    int'(bus.cfg_err),    0);
      chk("rst_pair_count", int'(bus.pair_count), 0);
      chk("rst_cfg_ready",  int'(bus.cfg_ready),  1);
      chk("rst_in_ready",   int'(bus.in_ready),   1);
      @(negedge clock);
      resetn = 1'b1;
   endtask

   initial begin
      int pairs [8][2];
      bus.cfg_clear = 0; bus.cfg_valid = 0; bus.cfg_a = '0; bus.cfg_b = '0;
      bus.in_valid = 0;  bus.in_letter = '0; bus.out_ready = 0;
      m_reset();
      repeat (2) @(negedge clock);
      async_reset();

      // Post-reset identity
      for (int l = 0; l < ALPHA; l++) send(l);
      idle(2);

      // Pair install and lookup
      pair(0, 16); pair(4, 9);
      send(0); send(16); send(4); send(9); send(3);
      idle(2);

      // Rejects: self-pair, already paired, out of range
      pair(5, 5); idle(1);
      pair(0, 7); idle(1);
      pair(27, 1); idle(1);

      // Fill to MAX_PAIRS then one more
      pairs = '{'{1,2}, '{3,5}, '{6,7}, '{8,10}, '{11,12}, '{13,14}, '{15,17}, '{18,19}};
      for (int i = 0; i < 8; i++) pair(pairs[i][0], pairs[i][1]);
      pair(20, 21); idle(2);

      // Backpressure
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, i + 3, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, i + 8, 1);
      idle(2);

      // Clear with a pending output, then cfg/data in the same cycle
      step(0, 0, 0, 0, 1, 16, 0);
      step(1, 1, 22, 23, 1, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 2, 0);
      for (int i = 0; i < 24; i++) step(0, 1, 22, 23, 1, 2, 1);
      send(16);
      step(0, 1, 2, 11, 1, 2, 1);
      send(2);
      idle(2);

      // Randomized traffic with a reset in the middle
      for (int i = 0; i < 3000; i++) begin
         int a, b, l;
         if (i == 1500) async_reset();
         a = ($urandom_range(0, 19) == 0) ? 31 : $urandom_range(0, 27);
         b = ($urandom_range(0, 19) == 0) ? 30 : $urandom_range(0, 27);
         l = ($urandom_range(0, 9) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
         step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 35), a, b,
              ($urandom_range(0, 99) < 70), l, ($urandom_range(0, 99) < 70));
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
